// File: rtl/soul_mover_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soul_mover_pkg
// Description : Shared types and constants for the soul position controller.
// Revision    : 1.0 - initial release
// ============================================================================
package soul_mover_pkg;

    localparam int COORD_W = 10;   // screen coordinate width
    localparam int INT_W   = 12;   // signed working width for clamp math
    localparam int HOLD_W  = 8;    // held-frame counter width

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        CALC_X = 3'd2,
        CALC_Y = 3'd3,
        COMMIT = 3'd4
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               hit;
    } clamp_t;

    // Zero-extend a screen coordinate into the signed working width.
    function automatic logic signed [INT_W-1:0] to_int(input logic [COORD_W-1:0] v);
        return signed'({{(INT_W-COORD_W){1'b0}}, v});
    endfunction

    // Saturating increment for the held-frame counter.
    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == {HOLD_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soul_mover_if.sv
`default_nettype none
// ============================================================================
// Module      : soul_mover_if
// Description : Frame/button/border inputs and position outputs of the
//               soul mover, bundled for connection to the battle-box logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface soul_mover_if;
    import soul_mover_pkg::*;

    logic               frame_tick;
    logic               enable;
    logic               btn_up;
    logic               btn_down;
    logic               btn_left;
    logic               btn_right;
    logic [COORD_W-1:0] border_x1;
    logic [COORD_W-1:0] border_x2;
    logic [COORD_W-1:0] border_y1;
    logic [COORD_W-1:0] border_y2;
    logic [COORD_W-1:0] player_x;
    logic [COORD_W-1:0] player_y;
    logic [COORD_W-1:0] player_r;
    logic               hit_x;
    logic               hit_y;
    logic               pos_valid;

    modport master (
        output frame_tick, enable, btn_up, btn_down, btn_left, btn_right,
        output border_x1, border_x2, border_y1, border_y2,
        input  player_x, player_y, player_r, hit_x, hit_y, pos_valid
    );

    modport slave (
        input  frame_tick, enable, btn_up, btn_down, btn_left, btn_right,
        input  border_x1, border_x2, border_y1, border_y2,
        output player_x, player_y, player_r, hit_x, hit_y, pos_valid
    );

endinterface
`default_nettype wire

// File: rtl/soul_mover_axis_clamp.sv
`default_nettype none
// ============================================================================
// Module      : soul_mover_axis_clamp
// Description : One-axis move-and-clamp. Applies delta*step to the current
//               centre and keeps the soul's radius inside [lo_edge, hi_edge].
// Revision    : 1.0 - initial release
// ============================================================================
module soul_mover_axis_clamp
    import soul_mover_pkg::*;
(
    input  logic [COORD_W-1:0]      i_pos,
    input  logic signed [1:0]       i_delta,
    input  logic signed [INT_W-1:0] i_step,
    input  logic [COORD_W-1:0]      i_lo_edge,
    input  logic [COORD_W-1:0]      i_hi_edge,
    input  logic [COORD_W-1:0]      i_radius,
    output clamp_t                  o_result
);

    logic signed [INT_W-1:0] w_pos;
    logic signed [INT_W-1:0] w_target;
    logic signed [INT_W-1:0] w_lo;
    logic signed [INT_W-1:0] w_hi;
    logic signed [INT_W-1:0] w_sum;

    // Compute target and allowed range, then pick centre / target / edge.
    always_comb begin
        w_pos = to_int(i_pos);
        w_lo  = to_int(i_lo_edge) + to_int(i_radius);
        w_hi  = to_int(i_hi_edge) - to_int(i_radius);
        w_sum = to_int(i_lo_edge) + to_int(i_hi_edge);

        // delta is only ever -1 (2'sb11), 0 or +1
        if (i_delta == 2'sd1) begin
            w_target = w_pos + i_step;
        end else if (i_delta == 2'sb11) begin
            w_target = w_pos - i_step;
        end else begin
            w_target = w_pos;
        end

        o_result.pos = COORD_W'(w_target);
        o_result.hit = 1'b0;
        if (w_hi < w_lo) begin
            // box narrower than the soul: park it in the middle
            o_result.pos = COORD_W'(w_sum >>> 1);
            o_result.hit = 1'b1;
        end else if (w_target > w_hi) begin
            o_result.pos = COORD_W'(w_hi);
            o_result.hit = 1'b1;
        end else if (w_target < w_lo) begin
            o_result.pos = COORD_W'(w_lo);
            o_result.hit = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/soul_mover.sv
`default_nettype none
// ============================================================================
// Module      : soul_mover
// Description : Per-frame soul position controller: samples buttons once per
//               frame, ramps speed while held, clamps to the battle box.
// Revision    : 1.0 - initial release
// ============================================================================
module soul_mover
    import soul_mover_pkg::*;
#(
    parameter int START_X     = 320,
    parameter int START_Y     = 240,
    parameter int RADIUS      = 8,
    parameter int STEP_MIN    = 1,
    parameter int STEP_MAX    = 3,
    parameter int RAMP_FRAMES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    soul_mover_if.slave  bus
);

    localparam logic [COORD_W-1:0] c_start_x  = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] c_start_y  = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] c_radius   = COORD_W'(RADIUS);
    localparam logic [INT_W-1:0]   c_step_min = INT_W'(STEP_MIN);
    localparam logic [INT_W-1:0]   c_step_max = INT_W'(STEP_MAX);
    localparam logic [HOLD_W-1:0]  c_ramp     = HOLD_W'(RAMP_FRAMES);

    state_t              r_state;
    logic signed [1:0]   r_dx;
    logic signed [1:0]   r_dy;
    logic [INT_W-1:0]    r_step;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [COORD_W-1:0]  r_x1, r_x2, r_y1, r_y2;
    clamp_t              r_cx;
    clamp_t              r_cy;
    logic [COORD_W-1:0]  r_player_x;
    logic [COORD_W-1:0]  r_player_y;
    logic                r_hit_x;
    logic                r_hit_y;
    logic                r_pos_valid;

    logic signed [1:0]   w_dx;
    logic signed [1:0]   w_dy;
    logic                w_moving;
    logic [INT_W-1:0]    w_ramp;
    logic [INT_W-1:0]    w_step;
    clamp_t              w_cx;
    clamp_t              w_cy;

    // Direction decode and speed ramp from the current button levels.
    always_comb begin
        w_dx = 2'sd0;
        w_dy = 2'sd0;
        if (bus.enable) begin
            w_dx = signed'({1'b0, bus.btn_right}) - signed'({1'b0, bus.btn_left});
            w_dy = signed'({1'b0, bus.btn_down})  - signed'({1'b0, bus.btn_up});
        end
        w_moving = (w_dx != 2'sd0) || (w_dy != 2'sd0);
        w_ramp   = c_step_min + INT_W'(r_hold_cnt / c_ramp);
        w_step   = (w_ramp > c_step_max) ? c_step_max : w_ramp;
    end

    soul_mover_axis_clamp u_clamp_x (
        .i_pos     (r_player_x),
        .i_delta   (r_dx),
        .i_step    (signed'(r_step)),
        .i_lo_edge (r_x1),
        .i_hi_edge (r_x2),
        .i_radius  (c_radius),
        .o_result  (w_cx)
    );

    soul_mover_axis_clamp u_clamp_y (
        .i_pos     (r_player_y),
        .i_delta   (r_dy),
        .i_step    (signed'(r_step)),
        .i_lo_edge (r_y1),
        .i_hi_edge (r_y2),
        .i_radius  (c_radius),
        .o_result  (w_cy)
    );

    // Frame sequencer: sample, clamp x, clamp y, commit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dx        <= 2'sd0;
            r_dy        <= 2'sd0;
            r_step      <= '0;
            r_hold_cnt  <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_player_x  <= c_start_x;
            r_player_y  <= c_start_y;
            r_hit_x     <= 1'b0;
            r_hit_y     <= 1'b0;
            r_pos_valid <= 1'b0;
        end else begin
            r_pos_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.frame_tick) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_dx       <= w_dx;
                    r_dy       <= w_dy;
                    // step uses the count of frames held before this one
                    r_step     <= w_step;
                    r_hold_cnt <= w_moving ? sat_inc(r_hold_cnt) : '0;
                    r_x1       <= bus.border_x1;
                    r_x2       <= bus.border_x2;
                    r_y1       <= bus.border_y1;
                    r_y2       <= bus.border_y2;
                    r_state    <= CALC_X;
                end
                CALC_X: begin
                    r_cx    <= w_cx;
                    r_state <= CALC_Y;
                end
                CALC_Y: begin
                    r_cy    <= w_cy;
                    r_state <= COMMIT;
                end
                COMMIT: begin
                    r_player_x  <= r_cx.pos;
                    r_player_y  <= r_cy.pos;
                    r_hit_x     <= r_cx.hit;
                    r_hit_y     <= r_cy.hit;
                    r_pos_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.player_x  = r_player_x;
    assign bus.player_y  = r_player_y;
    assign bus.player_r  = c_radius;
    assign bus.hit_x     = r_hit_x;
    assign bus.hit_y     = r_hit_y;
    assign bus.pos_valid = r_pos_valid;

endmodule
`default_nettype wire

// File: tb/tb_soul_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_soul_mover
// Description : Self-checking bench for soul_mover with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soul_mover;

    localparam int START_X = 320;
    localparam int START_Y = 240;
    localparam int R       = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    soul_mover_if bus ();

    soul_mover dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // model: p_* = latest computed position, c_* = position visible on outputs
    int m_hold = 0;
    int p_x = START_X, p_y = START_Y, p_hx = 0, p_hy = 0;
    int c_x = START_X, c_y = START_Y, c_hx = 0, c_hy = 0;
    int m_exp = -1;

    task automatic chk(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int clamp_axis(input int pos, input int d, input int step,
                                      input int e1, input int e2, output int hit);
        int lo, hi, t;
        lo = e1 + R;
        hi = e2 - R;
        t  = pos + d * step;
        hit = 1;
        if (hi < lo) return (e1 + e2) / 2;
        if (t > hi)  return hi;
        if (t < lo)  return lo;
        hit = 0;
        return t;
    endfunction

    // Apply one frame of the movement rules to the model, if the FSM is free.
    task automatic model_tick();
        int dx, dy, step;
        if (m_exp >= 0 && cyc < m_exp) return;
        dx = int'(bus.btn_right) - int'(bus.btn_left);
        dy = int'(bus.btn_down) - int'(bus.btn_up);
        if (!bus.enable) begin dx = 0; dy = 0; end
        step = 1 + m_hold / 8;
        if (step > 3) step = 3;
        if (dx != 0 || dy != 0) m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        else m_hold = 0;
        p_x = clamp_axis(p_x, dx, step, int'(bus.border_x1), int'(bus.border_x2), p_hx);
        p_y = clamp_axis(p_y, dy, step, int'(bus.border_y1), int'(bus.border_y2), p_hy);
        m_exp = cyc + 5;
    endtask

    task automatic model_reset();
        m_hold = 0;
        p_x = START_X; p_y = START_Y; p_hx = 0; p_hy = 0;
        c_x = START_X; c_y = START_Y; c_hx = 0; c_hy = 0;
        m_exp = -1;
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        bit v;
        v = (cyc == m_exp) && rst_n;
        if (v) begin
            c_x = p_x; c_y = p_y; c_hx = p_hx; c_hy = p_hy;
        end
        chk("pos_valid", 32'(bus.pos_valid), int'(v));
        chk("player_x",  32'(bus.player_x), c_x);
        chk("player_y",  32'(bus.player_y), c_y);
        chk("hit_x",     32'(bus.hit_x), c_hx);
        chk("hit_y",     32'(bus.hit_y), c_hy);
        chk("player_r",  32'(bus.player_r), R);
    end

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
    endtask

    task automatic set_box(input int x1, input int x2, input int y1, input int y2);
        bus.border_x1 = 10'(x1); bus.border_x2 = 10'(x2);
        bus.border_y1 = 10'(y1); bus.border_y2 = 10'(y2);
    endtask

    task automatic frame();
        @(negedge clk);
        model_tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic lit(input string tag, input int x, input int y, input int hx, input int hy);
        chk({tag, "_x"},  32'(bus.player_x), x);
        chk({tag, "_y"},  32'(bus.player_y), y);
        chk({tag, "_hx"}, 32'(bus.hit_x), hx);
        chk({tag, "_hy"}, 32'(bus.hit_y), hy);
        chk({tag, "_model_x"}, 32'(p_x), x);
        chk({tag, "_model_y"}, 32'(p_y), y);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b1;
        set_btn(0, 0, 0, 0);
        set_box(100, 540, 200, 400);
        model_reset();
        repeat (3) @(negedge clk);
        lit("reset", 320, 240, 0, 0);
        chk("reset_valid", 32'(bus.pos_valid), 0);
        #2 rst_n = 1'b1;

        // first frame with explicit latency checks: pulse exactly at N+5
        @(negedge clk);
        model_tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("lat_n4", 32'(bus.pos_valid), 0);
        @(negedge clk);
        chk("lat_n5", 32'(bus.pos_valid), 1);
        @(negedge clk);
        chk("lat_n6", 32'(bus.pos_valid), 0);
        lit("idle", 320, 240, 0, 0);

        // speed ramp: 1 x8, 2 x8, 3 x4
        set_btn(0, 0, 0, 1);
        repeat (20) frame();
        lit("ramp", 356, 240, 0, 0);

        // run to 530 at step 3, then one more frame hits the right edge
        repeat (58) frame();
        lit("to530", 530, 240, 0, 0);
        frame();
        lit("edge", 532, 240, 1, 0);

        // direction change keeps the ramp: step 3 leftwards
        set_btn(0, 0, 1, 0);
        repeat (4) frame();
        lit("left", 520, 240, 0, 0);

        // opposing buttons cancel and reset the ramp
        set_btn(0, 0, 1, 1);
        frame();
        lit("cancel", 520, 240, 0, 0);
        set_btn(0, 0, 0, 1);
        frame();
        lit("restep", 521, 240, 0, 0);

        // box narrower than 2R with movement disabled: still clamped
        set_btn(0, 0, 0, 0);
        bus.enable = 1'b0;
        set_box(300, 310, 200, 230);
        frame();
        lit("shrink", 305, 222, 1, 1);

        bus.enable = 1'b1;
        set_box(100, 540, 200, 400);
        set_btn(0, 1, 0, 0);
        frame();
        lit("down", 305, 223, 0, 0);

        // frame_tick arriving during CALC_X is ignored
        set_btn(0, 0, 0, 1);
        @(negedge clk);
        model_tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        model_tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (5) @(negedge clk);
        lit("ignore", 306, 223, 0, 0);

        // reset during CALC_Y: no commit, back to reset values
        @(negedge clk);
        model_tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        lit("midrst", 320, 240, 0, 0);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // ramp was cleared by reset: first frame steps by 1
        frame();
        lit("post", 321, 240, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
